// File: rtl/tpu_pkg.sv
// Shared types and constants for the 4x4 systolic matrix multiplier.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package tpu_pkg;

   localparam int ARR          = 4;
   localparam int DRAIN_CYCLES = 7;
   localparam int DW           = 8;
   localparam int AW           = 32;
   localparam int CW           = 128;

   typedef enum logic [3:0] {
      TPU_IDLE    = 4'd0,
      TPU_COMPUTE = 4'd1,
      TPU_WRITE   = 4'd2,
      TPU_DONE    = 4'd3
   } tpu_state_e;

   typedef enum logic [2:0] {
      SA_IDLE  = 3'd0,
      SA_CLEAR = 3'd1,
      SA_FEED  = 3'd2,
      SA_DRAIN = 3'd3
   } sa_state_e;

   // Number of 4-wide tiles needed to cover a dimension.
   function automatic logic [7:0] ceil4(input logic [7:0] v);
      logic [8:0] t;
      t = {1'b0, v} + 9'd3;
      return {1'b0, t[8:2]};
   endfunction

endpackage

// File: rtl/tpu_pe.sv
// Processing element: signed 8x8 MAC into a wrapping 32-bit accumulator, operands forwarded east/south.
// Latency: 1 cycle from operand input to accumulator update and to forwarded outputs.
// Backpressure: none; the array is fed in lock-step by the controller.
module tpu_pe
   import tpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   output logic [DW-1:0] a_o,
   output logic [DW-1:0] b_o,
   output logic [AW-1:0] acc_o
);

   logic signed [15:0] prod;
   logic [AW-1:0]      acc_q;
   logic [DW-1:0]      a_q, b_q;

   assign prod  = $signed(a_i) * $signed(b_i);
   assign acc_o = acc_q;
   assign a_o   = a_q;
   assign b_o   = b_q;

   // Accumulate the sign-extended product; clear wins so each tile starts from zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         acc_q <= clr_i ? '0 : acc_q + {{16{prod[15]}}, prod};
         a_q   <= a_i;
         b_q   <= b_i;
      end
   end

endmodule

// File: rtl/tpu_core.sv
// 4x4 output-stationary systolic matmul with tile controller, skew line and buffer addressing; TPU_DEBUG_EN drives the debug ports.
// Latency: ceil(M/4)*ceil(N/4)*(K+12) cycles of busy plus one DONE cycle per job.
// Backpressure: none; in_valid is accepted only in IDLE, buffers are assumed always ready.
module tpu_core
   import tpu_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [7:0]    K,
   input  logic [7:0]    M,
   input  logic [7:0]    N,
   output logic          busy,
   output logic          A_wr_en,
   output logic          B_wr_en,
   output logic [15:0]   A_index,
   output logic [15:0]   B_index,
   output logic [AW-1:0] A_data_in,
   output logic [AW-1:0] B_data_in,
   input  logic [AW-1:0] A_data_out,
   input  logic [AW-1:0] B_data_out,
   output logic          C_wr_en,
   output logic [15:0]   C_index,
   output logic [CW-1:0] C_data_in,
   input  logic [CW-1:0] C_data_out,
   output logic [3:0]    state_TPU_o,
   output logic [2:0]    state_SA_o,
   output logic [AW-1:0] local_buffer_A0_o,
   output logic [AW-1:0] local_buffer_A1_o,
   output logic [AW-1:0] local_buffer_A2_o,
   output logic [AW-1:0] local_buffer_A3_o,
   output logic [AW-1:0] local_buffer_B0_o,
   output logic [AW-1:0] local_buffer_B1_o,
   output logic [AW-1:0] local_buffer_B2_o,
   output logic [AW-1:0] local_buffer_B3_o,
   output logic [CW-1:0] local_buffer_C0_o,
   output logic [CW-1:0] local_buffer_C1_o,
   output logic [CW-1:0] local_buffer_C2_o,
   output logic [CW-1:0] local_buffer_C3_o,
   output logic [AW-1:0] result0_o,
   output logic [DW-1:0] inp_north0_o,
   output logic [DW-1:0] inp_north1_o,
   output logic [DW-1:0] inp_north2_o,
   output logic [DW-1:0] inp_north3_o,
   output logic [DW-1:0] inp_west0_o,
   output logic [DW-1:0] inp_west4_o,
   output logic [DW-1:0] inp_west8_o,
   output logic [DW-1:0] inp_west12_o
);

   tpu_state_e    tpu_q;
   sa_state_e     sa_q;
   logic          busy_q;
   logic [7:0]    k_q, m_q, mt_q, nt_q, mtiles_q, ntiles_q, cnt_q;
   logic [15:0]   a_idx_q, b_idx_q;
   logic          rd_vld_q;
   logic [AW-1:0] a_sk_q [ARR];
   logic [AW-1:0] b_sk_q [ARR];

   logic [DW-1:0] inp_west  [ARR];
   logic [DW-1:0] inp_north [ARR];
   logic [DW-1:0] a_fwd [ARR][ARR];
   logic [DW-1:0] b_fwd [ARR][ARR];
   logic [AW-1:0] acc   [ARR][ARR];
   logic [CW-1:0] row_pack [ARR];

   logic [15:0]   a_base, b_base, c_base;
   logic          clr, row_ok;

   assign a_base = {8'd0, mt_q} * {8'd0, k_q};
   assign b_base = {8'd0, nt_q} * {8'd0, k_q};
   assign c_base = {8'd0, nt_q} * {8'd0, m_q} + {6'd0, mt_q, 2'b00};
   assign clr    = (sa_q == SA_CLEAR);
   assign row_ok = ({mt_q[5:0], cnt_q[1:0]} < m_q);

   assign busy      = busy_q;
   assign A_wr_en   = 1'b0;
   assign B_wr_en   = 1'b0;
   assign A_data_in = '0;
   assign B_data_in = '0;
   assign A_index   = a_idx_q;
   assign B_index   = b_idx_q;

   // Controller: tile loop, array sub-states and fetch address generation in one registered FSM.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tpu_q    <= TPU_IDLE;
         sa_q     <= SA_IDLE;
         busy_q   <= 1'b0;
         k_q      <= '0;
         m_q      <= '0;
         mt_q     <= '0;
         nt_q     <= '0;
         mtiles_q <= '0;
         ntiles_q <= '0;
         cnt_q    <= '0;
         a_idx_q  <= '0;
         b_idx_q  <= '0;
      end else begin
         case (tpu_q)
            TPU_IDLE: begin
               if (in_valid) begin
                  busy_q   <= 1'b1;
                  k_q      <= K;
                  m_q      <= M;
                  mt_q     <= '0;
                  nt_q     <= '0;
                  cnt_q    <= '0;
                  mtiles_q <= ceil4(M);
                  ntiles_q <= ceil4(N);
                  if (K == 8'd0 || M == 8'd0 || N == 8'd0) begin
                     tpu_q <= TPU_DONE;
                  end else begin
                     tpu_q <= TPU_COMPUTE;
                     sa_q  <= SA_CLEAR;
                  end
               end
            end
            TPU_COMPUTE: begin
               case (sa_q)
                  SA_CLEAR: begin
                     sa_q    <= SA_FEED;
                     cnt_q   <= '0;
                     a_idx_q <= a_base;
                     b_idx_q <= b_base;
                  end
                  SA_FEED: begin
                     a_idx_q <= a_idx_q + 16'd1;
                     b_idx_q <= b_idx_q + 16'd1;
                     if (cnt_q == k_q - 8'd1) begin
                        sa_q  <= SA_DRAIN;
                        cnt_q <= '0;
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
                  SA_DRAIN: begin
                     if (cnt_q == 8'(DRAIN_CYCLES - 1)) begin
                        sa_q  <= SA_IDLE;
                        tpu_q <= TPU_WRITE;
                        cnt_q <= '0;
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
                  default: sa_q <= SA_IDLE;
               endcase
            end
            TPU_WRITE: begin
               if (cnt_q == 8'(ARR - 1)) begin
                  cnt_q <= '0;
                  if (nt_q + 8'd1 < ntiles_q) begin
                     nt_q  <= nt_q + 8'd1;
                     tpu_q <= TPU_COMPUTE;
                     sa_q  <= SA_CLEAR;
                  end else if (mt_q + 8'd1 < mtiles_q) begin
                     nt_q  <= '0;
                     mt_q  <= mt_q + 8'd1;
                     tpu_q <= TPU_COMPUTE;
                     sa_q  <= SA_CLEAR;
                  end else begin
                     tpu_q <= TPU_DONE;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            TPU_DONE: begin
               tpu_q  <= TPU_IDLE;
               busy_q <= 1'b0;
            end
            default: tpu_q <= TPU_IDLE;
         endcase
      end
   end

   // Skew line: stage 0 captures read data one cycle after each fetch, zero outside the feed window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld_q <= 1'b0;
         for (int i = 0; i < ARR; i++) begin
            a_sk_q[i] <= '0;
            b_sk_q[i] <= '0;
         end
      end else begin
         rd_vld_q  <= (tpu_q == TPU_COMPUTE) && (sa_q == SA_FEED);
         a_sk_q[0] <= rd_vld_q ? A_data_out : '0;
         b_sk_q[0] <= rd_vld_q ? B_data_out : '0;
         for (int i = 1; i < ARR; i++) begin
            a_sk_q[i] <= a_sk_q[i-1];
            b_sk_q[i] <= b_sk_q[i-1];
         end
      end
   end

   logic [ARR-1:0] unused_fwd;
   logic           unused_c;
   assign unused_c = ^C_data_out;

   for (genvar r = 0; r < ARR; r++) begin : g_row
      assign inp_west[r]  = a_sk_q[r][8*(ARR-1-r) +: 8];
      assign inp_north[r] = b_sk_q[r][8*(ARR-1-r) +: 8];
      assign row_pack[r]  = {acc[r][0], acc[r][1], acc[r][2], acc[r][3]};
      assign unused_fwd[r] = ^{a_fwd[r][ARR-1], b_fwd[ARR-1][r], a_sk_q[r], b_sk_q[r]};
      for (genvar c = 0; c < ARR; c++) begin : g_col
         logic [DW-1:0] a_in, b_in;
         if (c == 0) begin : g_w
            assign a_in = inp_west[r];
         end else begin : g_wi
            assign a_in = a_fwd[r][c-1];
         end
         if (r == 0) begin : g_n
            assign b_in = inp_north[c];
         end else begin : g_ni
            assign b_in = b_fwd[r-1][c];
         end
         tpu_pe u_pe (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (clr),
            .a_i   (a_in),
            .b_i   (b_in),
            .a_o   (a_fwd[r][c]),
            .b_o   (b_fwd[r][c]),
            .acc_o (acc[r][c])
         );
      end
   end

   // Write-back: one array row per WRITE cycle, rows past M suppressed.
   always_comb begin
      C_wr_en   = 1'b0;
      C_index   = '0;
      C_data_in = '0;
      if (tpu_q == TPU_WRITE && row_ok) begin
         C_wr_en   = 1'b1;
         C_index   = c_base + {14'd0, cnt_q[1:0]};
         C_data_in = row_pack[cnt_q[1:0]];
      end
   end

`ifdef TPU_DEBUG_EN
   assign state_TPU_o       = tpu_q;
   assign state_SA_o        = sa_q;
   assign local_buffer_A0_o = a_sk_q[0];
   assign local_buffer_A1_o = a_sk_q[1];
   assign local_buffer_A2_o = a_sk_q[2];
   assign local_buffer_A3_o = a_sk_q[3];
   assign local_buffer_B0_o = b_sk_q[0];
   assign local_buffer_B1_o = b_sk_q[1];
   assign local_buffer_B2_o = b_sk_q[2];
   assign local_buffer_B3_o = b_sk_q[3];
   assign local_buffer_C0_o = row_pack[0];
   assign local_buffer_C1_o = row_pack[1];
   assign local_buffer_C2_o = row_pack[2];
   assign local_buffer_C3_o = row_pack[3];
   assign result0_o         = acc[0][0];
   assign inp_north0_o      = inp_north[0];
   assign inp_north1_o      = inp_north[1];
   assign inp_north2_o      = inp_north[2];
   assign inp_north3_o      = inp_north[3];
   assign inp_west0_o       = inp_west[0];
   assign inp_west4_o       = inp_west[1];
   assign inp_west8_o       = inp_west[2];
   assign inp_west12_o      = inp_west[3];
`else
   assign state_TPU_o       = '0;
   assign state_SA_o        = '0;
   assign local_buffer_A0_o = '0;
   assign local_buffer_A1_o = '0;
   assign local_buffer_A2_o = '0;
   assign local_buffer_A3_o = '0;
   assign local_buffer_B0_o = '0;
   assign local_buffer_B1_o = '0;
   assign local_buffer_B2_o = '0;
   assign local_buffer_B3_o = '0;
   assign local_buffer_C0_o = '0;
   assign local_buffer_C1_o = '0;
   assign local_buffer_C2_o = '0;
   assign local_buffer_C3_o = '0;
   assign result0_o         = '0;
   assign inp_north0_o      = '0;
   assign inp_north1_o      = '0;
   assign inp_north2_o      = '0;
   assign inp_north3_o      = '0;
   assign inp_west0_o       = '0;
   assign inp_west4_o       = '0;
   assign inp_west8_o       = '0;
   assign inp_west12_o      = '0;
`endif

endmodule

// File: tb/tb_tpu_core.sv
// Directed bench for tpu_core: buffer models, golden matmul, one task per scenario.
// Latency: n/a.
// Backpressure: n/a.
module tb_tpu_core;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [7:0]   K = '0, M = '0, N = '0;
   logic         busy, A_wr_en, B_wr_en, C_wr_en;
   logic [15:0]  A_index, B_index, C_index;
   logic [31:0]  A_data_in, B_data_in, A_data_out, B_data_out;
   logic [127:0] C_data_in, C_data_out;
   logic [3:0]   state_TPU_o;
   logic [2:0]   state_SA_o;
   logic [31:0]  lba0, lba1, lba2, lba3, lbb0, lbb1, lbb2, lbb3, result0_o;
   logic [127:0] lbc0, lbc1, lbc2, lbc3;
   logic [7:0]   n0, n1, n2, n3, w0, w4, w8, w12;

   int n_pass = 0;
   int n_total = 0;

   logic [31:0]  a_mem [256];
   logic [31:0]  b_mem [256];
   logic [31:0]  a_rd = '0, b_rd = '0;
   logic [127:0] c_mem [256];
   int           c_epoch [256];
   int           epoch = 0;
   int           wr_total = 0;
   int           am [16][16];
   int           bm [16][16];

   assign A_data_out = a_rd;
   assign B_data_out = b_rd;
   assign C_data_out = '0;

   always #5 clk = ~clk;

   tpu_core dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .K(K), .M(M), .N(N), .busy(busy),
      .A_wr_en(A_wr_en), .B_wr_en(B_wr_en), .A_index(A_index), .B_index(B_index),
      .A_data_in(A_data_in), .B_data_in(B_data_in), .A_data_out(A_data_out), .B_data_out(B_data_out),
      .C_wr_en(C_wr_en), .C_index(C_index), .C_data_in(C_data_in), .C_data_out(C_data_out),
      .state_TPU_o(state_TPU_o), .state_SA_o(state_SA_o),
      .local_buffer_A0_o(lba0), .local_buffer_A1_o(lba1), .local_buffer_A2_o(lba2), .local_buffer_A3_o(lba3),
      .local_buffer_B0_o(lbb0), .local_buffer_B1_o(lbb1), .local_buffer_B2_o(lbb2), .local_buffer_B3_o(lbb3),
      .local_buffer_C0_o(lbc0), .local_buffer_C1_o(lbc1), .local_buffer_C2_o(lbc2), .local_buffer_C3_o(lbc3),
      .result0_o(result0_o),
      .inp_north0_o(n0), .inp_north1_o(n1), .inp_north2_o(n2), .inp_north3_o(n3),
      .inp_west0_o(w0), .inp_west4_o(w4), .inp_west8_o(w8), .inp_west12_o(w12)
   );

   // Global buffers: one-cycle synchronous read latency.
   always @(posedge clk) begin
      a_rd <= a_mem[A_index[7:0]];
      b_rd <= b_mem[B_index[7:0]];
   end

   // C buffer: capture writes mid-cycle, tagging each with the current job.
   always @(negedge clk) begin
      if (C_wr_en === 1'b1) begin
         c_mem[C_index[7:0]]   <= C_data_in;
         c_epoch[C_index[7:0]] <= epoch;
         wr_total              <= wr_total + 1;
      end
   end

   function automatic logic [127:0] exp_word(input int row, input int nt, input int k, input int n);
      logic [127:0] w;
      w = '0;
      for (int j = 0; j < 4; j++) begin
         int s;
         s = 0;
         if (4*nt + j < n)
            for (int kk = 0; kk < k; kk++) s += am[row][kk] * bm[kk][4*nt+j];
         w[32*(3-j) +: 32] = s;
      end
      return w;
   endfunction

   task automatic load_mem(input int k, input int m, input int n);
      for (int i = 0; i < 256; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
      for (int mt = 0; mt < (m+3)/4; mt++)
         for (int kk = 0; kk < k; kk++)
            for (int j = 0; j < 4; j++)
               if (4*mt + j < m) a_mem[mt*k+kk][8*(3-j) +: 8] = am[4*mt+j][kk][7:0];
      for (int nt = 0; nt < (n+3)/4; nt++)
         for (int kk = 0; kk < k; kk++)
            for (int j = 0; j < 4; j++)
               if (4*nt + j < n) b_mem[nt*k+kk][8*(3-j) +: 8] = bm[kk][4*nt+j][7:0];
   endtask

   task automatic start_job(input int k, input int m, input int n);
      @(negedge clk);
      epoch++;
      K = 8'(k); M = 8'(m); N = 8'(n);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts cycles with busy high after the start; optionally pulses in_valid mid-job.
   task automatic wait_done(input bit pulse, output int cyc);
      cyc = 0;
      while (busy === 1'b1 && cyc < 5000) begin
         cyc++;
         if (pulse && cyc == 5) begin
            in_valid = 1'b1; K = 8'd9; M = 8'd8; N = 8'd8;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (cyc >= 5000) $display("FAIL wait_done: busy still high after %0d cycles", cyc);
      @(negedge clk);
   endtask

   task automatic set_identity(input int k);
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) begin
            am[i][j] = (i == j) ? 1 : 0;
            bm[i][j] = 4*i + j + 1;
         end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++;
      if (state_TPU_o !== 4'd0 || state_SA_o !== 3'd0)
         $display("FAIL reset_states: got %0d/%0d want 0/0", state_TPU_o, state_SA_o); else n_pass++;
      n_total++;
      if (C_wr_en !== 1'b0 || C_index !== 16'd0 || C_data_in !== 128'd0)
         $display("FAIL reset_c: got en=%b idx=%h want 0", C_wr_en, C_index); else n_pass++;
      n_total++;
      if ({A_index, B_index} !== 32'd0 || {A_wr_en, B_wr_en} !== 2'b00 || {A_data_in, B_data_in} !== 64'd0)
         $display("FAIL reset_ab: got %h %h want 0", A_index, B_index); else n_pass++;
      n_total++;
      if (lbc0 !== 128'd0 || result0_o !== 32'd0 || lba0 !== 32'd0 || w0 !== 8'd0)
         $display("FAIL reset_debug: got %h %h want 0", lbc0, result0_o); else n_pass++;
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      int cyc, w0c;
      set_identity(4);
      load_mem(4, 4, 4);
      w0c = wr_total;
      start_job(4, 4, 4);
      wait_done(1'b0, cyc);
      n_total++;
      if (cyc !== 17) $display("FAIL ident_cycles: got %0d want 17", cyc); else n_pass++;
      n_total++;
      if (wr_total - w0c !== 4) $display("FAIL ident_writes: got %0d want 4", wr_total - w0c); else n_pass++;
      n_total++;
      if (c_epoch[0] !== epoch || c_mem[0] !== {32'd1, 32'd2, 32'd3, 32'd4})
         $display("FAIL ident_c0: got %h want 1,2,3,4", c_mem[0]); else n_pass++;
      n_total++;
      if (c_epoch[3] !== epoch || c_mem[3] !== {32'd13, 32'd14, 32'd15, 32'd16})
         $display("FAIL ident_c3: got %h want 13,14,15,16", c_mem[3]); else n_pass++;
      n_total++;
      if (c_epoch[1] !== epoch || c_mem[1] !== {32'd5, 32'd6, 32'd7, 32'd8})
         $display("FAIL ident_c1: got %h want 5,6,7,8", c_mem[1]); else n_pass++;
   endtask

   task automatic test_signed();
      int cyc;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) begin am[i][j] = -1; bm[i][j] = 2; end
      load_mem(8, 4, 4);
      start_job(8, 4, 4);
      wait_done(1'b0, cyc);
      n_total++;
      if (cyc !== 21) $display("FAIL signed_cycles: got %0d want 21", cyc); else n_pass++;
      for (int r = 0; r < 4; r++) begin
         n_total++;
         if (c_epoch[r] !== epoch || c_mem[r] !== {4{32'hFFFF_FFF0}})
            $display("FAIL signed_c%0d: got %h want all fffffff0", r, c_mem[r]); else n_pass++;
      end
   endtask

   task automatic test_ragged();
      int cyc, w0c;
      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++) begin
            am[i][j] = int'($urandom_range(255)) - 128;
            bm[i][j] = int'($urandom_range(255)) - 128;
         end
      load_mem(3, 6, 5);
      w0c = wr_total;
      start_job(3, 6, 5);
      wait_done(1'b0, cyc);
      n_total++;
      if (cyc !== 61) $display("FAIL ragged_cycles: got %0d want 61", cyc); else n_pass++;
      n_total++;
      if (wr_total - w0c !== 12) $display("FAIL ragged_writes: got %0d want 12", wr_total - w0c); else n_pass++;
      for (int nt = 0; nt < 2; nt++)
         for (int row = 0; row < 6; row++) begin
            logic [127:0] e;
            e = exp_word(row, nt, 3, 5);
            n_total++;
            if (c_epoch[nt*6+row] !== epoch || c_mem[nt*6+row] !== e)
               $display("FAIL ragged_c%0d: got %h want %h", nt*6+row, c_mem[nt*6+row], e); else n_pass++;
         end
   endtask

   task automatic test_handshake();
      int cyc, w0c;
      set_identity(2);
      load_mem(2, 4, 4);
      w0c = wr_total;
      start_job(2, 4, 4);
      n_total++;
      if (busy !== 1'b1) $display("FAIL hs_busy_rise: got %b want 1", busy); else n_pass++;
      wait_done(1'b1, cyc);
      n_total++;
      if (cyc !== 15) $display("FAIL hs_cycles: got %0d want 15", cyc); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || wr_total - w0c !== 4)
         $display("FAIL hs_ignored: got busy=%b writes=%0d want 0/4", busy, wr_total - w0c); else n_pass++;
      n_total++;
      if (c_mem[1] !== {32'd5, 32'd6, 32'd7, 32'd8} || c_mem[2] !== 128'd0)
         $display("FAIL hs_result: got %h %h want 5,6,7,8 and 0", c_mem[1], c_mem[2]); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int cyc, w0c;
      set_identity(8);
      load_mem(8, 4, 4);
      w0c = wr_total;
      start_job(8, 4, 4);
      repeat (3) @(negedge clk);
`ifdef TPU_DEBUG_EN
      n_total++;
      if (state_SA_o !== 3'd2) $display("FAIL rst_mid_feed: got %0d want 2", state_SA_o); else n_pass++;
`endif
      rst_n = 1'b0;
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0 || state_TPU_o !== 4'd0 || state_SA_o !== 3'd0)
         $display("FAIL rst_mid_state: got busy=%b %0d/%0d want 0", busy, state_TPU_o, state_SA_o); else n_pass++;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      n_total++;
      if (wr_total !== w0c) $display("FAIL rst_mid_nowrite: got %0d writes want 0", wr_total - w0c); else n_pass++;
      set_identity(4);
      load_mem(4, 4, 4);
      start_job(4, 4, 4);
      wait_done(1'b0, cyc);
      n_total++;
      if (c_epoch[3] !== epoch || c_mem[3] !== {32'd13, 32'd14, 32'd15, 32'd16} || cyc !== 17)
         $display("FAIL rst_mid_rerun: got %h cyc=%0d want 13..16 cyc=17", c_mem[3], cyc); else n_pass++;
   endtask

   task automatic test_zero();
      int cyc, w0c;
      w0c = wr_total;
      start_job(4, 4, 0);
      wait_done(1'b0, cyc);
      n_total++;
      if (cyc !== 1) $display("FAIL zero_cycles: got %0d want 1", cyc); else n_pass++;
      n_total++;
      if (wr_total !== w0c) $display("FAIL zero_writes: got %0d want 0", wr_total - w0c); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_signed();
      test_ragged();
      test_handshake();
      test_reset_mid();
      test_zero();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
